// File: rtl/stack_pkg.sv
// stack_pkg: command/function encodings and default sizing for the stack controller
package stack_pkg;
    typedef enum logic [1:0] {OP_PUSH, OP_POP, OP_BINOP, OP_DUP} op_e;
    typedef enum logic [1:0] {FN_ADD, FN_SUB, FN_AND, FN_OR} fn_e;
    localparam int DEF_DEPTH = 32;
    localparam int DEF_W = 8;
endpackage

// File: rtl/stack_alu.sv
// stack_alu: combinational binary operator y = b fn a (b is the entry below a)
// Ports: b, a operands; fn selects ADD/SUB/AND/OR; y result, modulo 2^W
module stack_alu
    import stack_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic [W-1:0] b,
    input  logic [W-1:0] a,
    input  fn_e          fn,
    output logic [W-1:0] y
);
    always_comb
        y = fn == FN_ADD ? b + a : fn == FN_SUB ? b - a : fn == FN_AND ? b & a : b | a;
endmodule

// File: rtl/stack_ctrl.sv
// stack_ctrl: command sequencer driving an external stack (PUSH/POP/BINOP/DUP)
// Ports: cmd_valid/cmd_ready/cmd_op/cmd_fn/cmd_data command in; done/err/result
//        completion; depth entry count; stk_push/stk_pop/stk_tos/stk_din/stk_dout stack side
module stack_ctrl
    import stack_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int W = DEF_W,
    localparam int DW = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [1:0]    cmd_fn,
    input  logic [W-1:0]  cmd_data,
    output logic          done,
    output logic          err,
    output logic [W-1:0]  result,
    output logic [DW-1:0] depth,
    output logic          stk_push,
    output logic          stk_pop,
    output logic          stk_tos,
    output logic [W-1:0]  stk_din,
    input  logic [W-1:0]  stk_dout
);
    typedef enum logic [2:0] {IDLE, POP_A, POP_B, LAT_B, PUSH_R, PUSH_D, DONE} state_e;
    localparam logic [DW-1:0] FULL = DW'(DEPTH);
    state_e state, next;
    op_e op_q, in_op;
    fn_e fn_q;
    logic [W-1:0] val, op_a, alu_y;
    logic rej, rej_q, second;
    assign in_op = op_e'(cmd_op);
    // DUP pops one and pushes two, so it needs one free slot as well as one entry
    assign rej = in_op == OP_PUSH ? depth == FULL :
                 in_op == OP_POP  ? depth == '0 :
                 in_op == OP_DUP  ? (depth == '0 || depth == FULL) :
                 depth < DW'(2);
    assign stk_tos = 1'b0;
    stack_alu #(.W(W)) u_alu (.b(stk_dout), .a(op_a), .fn(fn_q), .y(alu_y));
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= next;
    always_comb begin
        next = state;
        cmd_ready = 1'b0;
        stk_push = 1'b0;
        stk_pop = 1'b0;
        stk_din = '0;
        done = 1'b0;
        err = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) next = rej ? DONE : in_op == OP_PUSH ? PUSH_R : POP_A;
            end
            POP_A: begin
                stk_pop = 1'b1;
                next = POP_B;
            end
            POP_B: begin
                stk_pop = op_q == OP_BINOP;
                next = op_q == OP_BINOP ? LAT_B : op_q == OP_POP ? DONE : PUSH_D;
            end
            LAT_B: next = PUSH_R;
            PUSH_R: begin
                stk_push = 1'b1;
                stk_din = val;
                next = DONE;
            end
            PUSH_D: begin
                stk_push = 1'b1;
                stk_din = op_a;
                next = second ? DONE : PUSH_D;
            end
            DONE: begin
                done = 1'b1;
                err = rej_q;
                next = IDLE;
            end
            default: next = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            depth <= '0;
            result <= '0;
            op_q <= OP_PUSH;
            fn_q <= FN_ADD;
            val <= '0;
            op_a <= '0;
            rej_q <= 1'b0;
            second <= 1'b0;
        end else begin
            second <= state == PUSH_D && !second;
            if (stk_push) depth <= depth + 1'b1;
            else if (stk_pop) depth <= depth - 1'b1;
            if (state == IDLE && cmd_valid) begin
                op_q <= in_op;
                fn_q <= fn_e'(cmd_fn);
                val <= cmd_data;
                rej_q <= rej;
            end
            if (state == POP_B) begin
                op_a <= stk_dout;
                if (op_q != OP_BINOP) result <= stk_dout;
            end
            if (state == LAT_B) val <= alu_y;
            if (state == PUSH_R) result <= val;
        end
endmodule

// File: tb/tb_stack_ctrl.sv
// tb_stack_ctrl: randomized and directed checks of stack_ctrl against a queue-based stack model
module tb_stack_ctrl;
    logic clk = 0, rst = 0, cmd_valid = 0;
    logic [1:0] cmd_op = 0, cmd_fn = 0;
    logic [7:0] cmd_data = 0;
    logic cmd_ready, done, err, stk_push, stk_pop, stk_tos;
    logic [7:0] result, stk_din, stk_dout;
    logic [5:0] depth;
    int n_tests = 0, n_fail = 0;
    logic [7:0] q[$];
    logic [7:0] last_res = 0;
    logic [7:0] smem [64];
    int sp;

    stack_ctrl #(.DEPTH(32), .W(8)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_fn(cmd_fn), .cmd_data(cmd_data), .done(done),
        .err(err), .result(result), .depth(depth), .stk_push(stk_push),
        .stk_pop(stk_pop), .stk_tos(stk_tos), .stk_din(stk_din), .stk_dout(stk_dout)
    );

    always #5 clk = ~clk;

    // attached stack memory: read data appears the cycle after a pop
    always @(posedge clk or posedge rst)
        if (rst) begin
            sp <= 0;
            stk_dout <= 8'h00;
        end else if (stk_push) begin
            if (sp < 64) smem[sp] <= stk_din;
            sp <= sp + 1;
        end else if (stk_pop) begin
            stk_dout <= (sp > 0 && sp <= 64) ? smem[sp-1] : 8'h00;
            sp <= sp - 1;
        end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model(input logic [1:0] op, input logic [1:0] fn, input logic [7:0] data,
                         output logic e, output int lat, output int npush, output int npop);
        int n = q.size();
        logic [7:0] a, b;
        e = (op == 0 && n == 32) || (op == 1 && n == 0) || (op == 2 && n < 2) ||
            (op == 3 && (n == 0 || n == 32));
        lat = 1; npush = 0; npop = 0;
        if (!e)
            case (op)
                0: begin q.push_back(data); last_res = data; lat = 2; npush = 1; end
                1: begin last_res = q.pop_back(); lat = 3; npop = 1; end
                2: begin
                    a = q.pop_back();
                    b = q.pop_back();
                    last_res = fn == 0 ? 8'(b + a) : fn == 1 ? 8'(b - a) : fn == 2 ? (b & a) : (b | a);
                    q.push_back(last_res);
                    lat = 5; npush = 1; npop = 2;
                end
                default: begin
                    a = q[$];
                    q.push_back(a);
                    last_res = a;
                    lat = 5; npush = 2; npop = 1;
                end
            endcase
    endtask

    // entered and left at a negedge with the DUT idle
    task automatic run_cmd(input logic [1:0] op, input logic [1:0] fn, input logic [7:0] data);
        logic e;
        int lat, npush, npop, k, pu = 0, po = 0;
        bit both = 0, got = 0;
        model(op, fn, data, e, lat, npush, npop);
        chk("ready_idle", cmd_ready, 1);
        cmd_valid = 1; cmd_op = op; cmd_fn = fn; cmd_data = data;
        @(posedge clk);
        #1 cmd_valid = 0; cmd_op = 2'($urandom); cmd_fn = 2'($urandom); cmd_data = 8'($urandom);
        for (k = 1; k <= 12; k++) begin
            @(negedge clk);
            pu += int'(stk_push);
            po += int'(stk_pop);
            both |= stk_push && stk_pop;
            if (done) begin got = 1; break; end
        end
        chk("done_seen", got, 1);
        chk("latency", k, lat);
        chk("err", err, e);
        chk("result", result, last_res);
        chk("depth", depth, q.size());
        chk("push_cnt", pu, npush);
        chk("pop_cnt", po, npop);
        chk("strobe_excl", both, 0);
        chk("ready_in_done", cmd_ready, 0);
        @(negedge clk);
        chk("done_pulse", done, 0);
        chk("ready_after", cmd_ready, 1);
    endtask

    task automatic do_reset();
        cmd_valid = 0;
        rst = 1;
        #1;
        chk("rst_state", {cmd_ready, done, err, stk_push, stk_pop, stk_tos}, 6'b100000);
        chk("rst_depth", depth, 0);
        chk("rst_result", result, 0);
        chk("rst_din", stk_din, 0);
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        q.delete();
        last_res = 0;
    endtask

    initial begin
        int seen;
        @(negedge clk);
        do_reset();
        run_cmd(0, 0, 8'h05);
        run_cmd(0, 0, 8'h03);
        run_cmd(2, 1, 8'h00);
        chk("sub_5_3", result, 8'h02);
        chk("sub_depth", depth, 1);
        do_reset();
        run_cmd(1, 0, 8'h00);
        chk("pop_empty_depth", depth, 0);
        do_reset();
        for (int i = 0; i < 32; i++) run_cmd(0, 0, 8'($urandom));
        run_cmd(0, 0, 8'hAA);
        chk("full_depth", depth, 32);
        run_cmd(3, 0, 8'h00);
        do_reset();
        run_cmd(0, 0, 8'h7F);
        run_cmd(3, 0, 8'h00);
        run_cmd(2, 0, 8'h00);
        chk("dup_add", result, 8'hFE);
        run_cmd(1, 0, 8'h00);
        chk("pop_fe", result, 8'hFE);
        chk("pop_depth", depth, 0);
        do_reset();
        run_cmd(0, 0, 8'h00);
        run_cmd(0, 0, 8'h01);
        run_cmd(2, 1, 8'h00);
        chk("sub_wrap", result, 8'hFF);
        do_reset();
        run_cmd(0, 0, 8'h05);
        run_cmd(0, 0, 8'h03);
        cmd_valid = 1; cmd_op = 2; cmd_fn = 0;
        @(posedge clk);
        #1 cmd_valid = 0;
        repeat (3) @(negedge clk);
        chk("busy_lat_b", cmd_ready, 0);
        rst = 1;
        #1;
        chk("mid_rst_ready", cmd_ready, 1);
        chk("mid_rst_result", result, 0);
        chk("mid_rst_strobes", {stk_push, stk_pop, done}, 0);
        seen = 0;
        @(negedge clk);
        rst = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            seen += int'(done);
        end
        chk("mid_rst_no_done", seen, 0);
        chk("mid_rst_depth", depth, 0);
        chk("mid_rst_ready_after", cmd_ready, 1);
        q.delete();
        last_res = 0;
        for (int i = 0; i < 400; i++)
            run_cmd($urandom_range(0, 9) < 4 ? 2'd0 : 2'($urandom), 2'($urandom), 8'($urandom));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
